// File: rtl/uart_rx.sv
// Serial receiver for 8N1-style frames: a 2-flop rx synchronizer feeds a start/data/stop FSM clocked by a 16x s_tick.
// Each completed frame, valid or with a framing error, pulses rx_done_tick one clk after the tick that samples the stop bit.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            rx_busy
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    case (state_q)
      // Start detection is not tick-gated, so the half-bit count begins on the first low clk.
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == 5'd7) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            dout_d  = b_q;
            ferr_d  = ~rx_s_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_dout      = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: s_tick every 4 clks (64-clk bit time); frames are driven serially and completions
// are compared against expected words computed from the data and stop-bit level that were sent.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx, rx32;
  logic [7:0] rx_dout, rx_dout32;
  logic       rx_done_tick, rx_done_tick32;
  logic       frame_err, frame_err32;
  logic       rx_busy, rx_busy32;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
    .rx_dout(rx_dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx32),
    .rx_dout(rx_dout32), .rx_done_tick(rx_done_tick32), .frame_err(frame_err32), .rx_busy(rx_busy32)
  );

  always #5 clk = ~clk;

  int tc = 0;
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tc++;
      s_tick = (tc % 4 == 0);
    end
  end

  // Completion monitor: records every rx_done_tick with its data, error flag and cycle stamp.
  int         mcyc = 0;
  logic [7:0] ev_d[$], ev32_d[$];
  logic       ev_f[$], ev32_f[$];
  int         ev_c[$], ev32_c[$];
  int         wide = 0, wide32 = 0;
  logic       prev_done = 1'b0, prev_done32 = 1'b0;
  logic       busy_seen = 1'b0;

  always @(negedge clk) begin
    mcyc++;
    if (rx_done_tick) begin
      ev_d.push_back(rx_dout); ev_f.push_back(frame_err); ev_c.push_back(mcyc);
    end
    if (rx_done_tick32) begin
      ev32_d.push_back(rx_dout32); ev32_f.push_back(frame_err32); ev32_c.push_back(mcyc);
    end
    if (rx_done_tick && prev_done) wide++;
    if (rx_done_tick32 && prev_done32) wide32++;
    prev_done   = rx_done_tick;
    prev_done32 = rx_done_tick32;
    if (rx_busy) busy_seen = 1'b1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic drive(input bit sel, input logic b, input int n);
    if (sel) rx32 = b; else rx = b;
    repeat (n) @(negedge clk);
  endtask

  // A low stop bit is held for 40 clks only, so the line is back high before any re-armed start is sampled.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stopb,
                            input int nstop, input int gap);
    drive(sel, 1'b0, 64);
    for (int i = 0; i < 8; i++) drive(sel, d[i], 64);
    if (stopb) drive(sel, 1'b1, 64 * nstop);
    else begin
      drive(sel, 1'b0, 40);
      drive(sel, 1'b1, 24);
    end
    drive(sel, 1'b1, gap);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stopb;
    int         gap;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;

  vec_t       tbl[5];
  logic [8:0] exp_q[$];
  logic [7:0] v81;
  int         base, t0, c1, base0;
  logic [7:0] rd;
  logic       rs;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 64, 8'hA5, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 0,  8'h00, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 64, 8'hFF, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, 64, 8'h3C, 1'b1};
    tbl[4] = '{8'h55, 1'b1, 64, 8'h55, 1'b0};
    c1 = 0;

    rx = 1'b1; rx32 = 1'b1; reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_dout", rx_dout, 8'h00);
    chk("rst_done", rx_done_tick, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    chk("rst_busy32", rx_busy32, 1'b0);

    for (int i = 0; i < 5; i++) begin
      base = ev_d.size();
      t0   = mcyc;
      send_frame(1'b0, tbl[i].d, tbl[i].stopb, 1, tbl[i].gap);
      chk($sformatf("vec%0d_count", i), ev_d.size() - base, 1);
      chk($sformatf("vec%0d_busy", i), rx_busy, 1'b0);
      if (ev_d.size() > base) begin
        chk($sformatf("vec%0d_dout", i), ev_d[base], tbl[i].exp_d);
        chk($sformatf("vec%0d_ferr", i), ev_f[base], tbl[i].exp_fe);
        chk_rng($sformatf("vec%0d_latency", i), ev_c[base] - t0, 600, 616);
        if (i == 1) c1 = ev_c[base];
        if (i == 2) chk_rng("b2b_spacing", ev_c[base] - c1, 636, 644);
      end
    end

    // Short glitch: 5 ticks low on an idle line.
    base = ev_d.size();
    busy_seen = 1'b0;
    drive(1'b0, 1'b0, 20);
    drive(1'b0, 1'b1, 200);
    chk("glitch_busy_seen", busy_seen, 1'b1);
    chk("glitch_busy_end", rx_busy, 1'b0);
    chk("glitch_count", ev_d.size() - base, 0);
    chk("glitch_dout", rx_dout, 8'h55);

    // Reset in the middle of data bit 4 of 0x81.
    base = ev_d.size();
    v81  = 8'h81;
    drive(1'b0, 1'b0, 64);
    for (int i = 0; i < 4; i++) drive(1'b0, v81[i], 64);
    drive(1'b0, v81[4], 32);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 300);
    chk("abort_count", ev_d.size() - base, 0);
    chk("abort_dout", rx_dout, 8'h00);
    chk("abort_ferr", frame_err, 1'b0);
    chk("abort_busy", rx_busy, 1'b0);
    send_frame(1'b0, 8'h81, 1'b1, 1, 64);
    chk("after_abort_count", ev_d.size() - base, 1);
    chk("after_abort_dout", rx_dout, 8'h81);
    chk("after_abort_ferr", frame_err, 1'b0);

    // Random frames against an expected-word queue: word = data, error = stop bit was low.
    base0 = ev_d.size();
    for (int i = 0; i < 12; i++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      exp_q.push_back({rd, ~rs});
      send_frame(1'b0, rd, rs, 1, $urandom_range(0, 80));
    end
    chk("rand_count", ev_d.size() - base0, 12);
    for (int i = 0; i < 12; i++) begin
      if (base0 + i < ev_d.size())
        chk($sformatf("rand%0d", i), {ev_d[base0 + i], ev_f[base0 + i]}, exp_q[i]);
    end

    // Two stop bits on the SB_TICK=32 instance.
    base = ev32_d.size();
    t0   = mcyc;
    send_frame(1'b1, 8'h5A, 1'b1, 2, 64);
    chk("sb32_count", ev32_d.size() - base, 1);
    if (ev32_d.size() > base) begin
      chk("sb32_dout", ev32_d[base], 8'h5A);
      chk("sb32_ferr", ev32_f[base], 1'b0);
      chk_rng("sb32_latency", ev32_c[base] - t0, 664, 680);
    end

    chk("done_width", wide, 0);
    chk("done_width32", wide32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
